// File: rtl/final_out_deser.sv
// rtl/final_out_deser.sv - serial-to-parallel word packer with output FIFO
//
// Packs MSB-first bursts from a 1-bit valid-qualified stream into left-aligned
// WIDTH-bit words. Each word is tagged with its bit count and an end-of-burst
// flag, buffered in a DEPTH-entry FIFO, and offered on a valid/ready port.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   sin         in   serial data bit
//   sin_valid   in   sin is valid this cycle
//   dout        out  head-of-FIFO word, left-aligned, LSB zero-padded
//   dout_nbits  out  meaningful bits in dout (1..WIDTH)
//   dout_last   out  dout is the final word of its burst
//   dout_valid  out  FIFO non-empty
//   dout_ready  in   consumer accepts the head word
//   overflow    out  sticky: a word was dropped on a full FIFO

module final_out_deser #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int NW    = $clog2(WIDTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] dout,
    output logic [NW-1:0]    dout_nbits,
    output logic             dout_last,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overflow
);

    localparam int EW = WIDTH + NW + 1;

    logic [WIDTH-1:0] sh;
    logic [NW-1:0]    cnt;

    logic             push;
    logic [WIDTH-1:0] push_data;
    logic [NW-1:0]    push_nbits;
    logic             push_last;
    logic [NW-1:0]    pad;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             wr;
    logic [EW-1:0]    head;

    // A full word is only released once the next bit proves the burst goes
    // on (LAST=0); otherwise the idle cycle flushes it with LAST=1.
    always_comb begin
        push       = 1'b0;
        push_data  = sh;
        push_nbits = cnt;
        push_last  = 1'b0;
        pad        = NW'(WIDTH) - cnt;
        if (sin_valid) begin
            if (cnt == NW'(WIDTH)) begin
                push       = 1'b1;
                push_nbits = NW'(WIDTH);
            end
        end else if (cnt != '0) begin
            push      = 1'b1;
            push_data = sh << pad;
            push_last = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (sin_valid) begin
            if (cnt == NW'(WIDTH)) begin
                sh  <= {{(WIDTH-1){1'b0}}, sin};
                cnt <= NW'(1);
            end else begin
                sh  <= {sh[WIDTH-2:0], sin};
                cnt <= cnt + NW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

    assign full       = (count == (AW+1)'(DEPTH));
    assign dout_valid = (count != '0);
    assign pop        = dout_valid && dout_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr         = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr && !pop)
                count <= count + (AW+1)'(1);
            else if (!wr && pop)
                count <= count - (AW+1)'(1);
            if (push && !wr)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= {push_data, push_nbits, push_last};
    end

    // Head is masked while empty so outputs read zero in reset.
    assign head       = dout_valid ? mem[rd_ptr] : '0;
    assign dout       = head[EW-1 -: WIDTH];
    assign dout_nbits = head[NW:1];
    assign dout_last  = head[0];

endmodule

// File: tb/tb_final_out_deser.sv
// tb/tb_final_out_deser.sv - self-checking bench for final_out_deser
module tb_final_out_deser;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sin;
    logic          sin_valid;
    logic [W-1:0]  dout;
    logic [NW-1:0] dout_nbits;
    logic          dout_last;
    logic          dout_valid;
    logic          dout_ready;
    logic          overflow;

    final_out_deser #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .dout       (dout),
        .dout_nbits (dout_nbits),
        .dout_last  (dout_last),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    // Model: bits of the burst in progress, expected FIFO contents, sticky flag.
    bit          burst[$];
    logic [12:0] exp_q[$];
    logic        exp_ovf;
    logic [12:0] popped[$];
    logic [12:0] want[$];
    int          valid_cycles;

    function automatic logic [12:0] make_word(input int n, input logic last);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v[W-1-i] = burst[i];
        return {v, NW'(n), last};
    endfunction

    always @(posedge clk) begin
        logic        mpop;
        logic        mpush;
        logic [12:0] w;
        if (rst_n && dout_valid && dout_ready)
            popped.push_back({dout, dout_nbits, dout_last});
        if (rst_n && dout_valid)
            valid_cycles++;
        if (!rst_n) begin
            burst.delete();
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            mpop  = (exp_q.size() != 0) && dout_ready;
            mpush = 1'b0;
            w     = '0;
            if (sin_valid) begin
                if (burst.size() == W) begin
                    w = make_word(W, 1'b0);
                    mpush = 1'b1;
                    burst.delete();
                end
                burst.push_back(sin);
            end else if (burst.size() > 0) begin
                w = make_word(burst.size(), 1'b1);
                mpush = 1'b1;
                burst.delete();
            end
            if (mpop)
                void'(exp_q.pop_front());
            if (mpush) begin
                if (exp_q.size() < D)
                    exp_q.push_back(w);
                else
                    exp_ovf = 1'b1;
            end
        end
        #1;
        chk("dout_valid", dout_valid, exp_q.size() != 0);
        chk("overflow", overflow, exp_ovf);
        if (exp_q.size() != 0)
            chk("head_word", {dout, dout_nbits, dout_last}, exp_q[0]);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            sin_valid = 1'b1;
            sin       = v[i];
        end
    endtask

    task automatic end_burst();
        @(negedge clk);
        sin_valid = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_dout"},  dout, 0);
        chk({nm, "_nbits"}, dout_nbits, 0);
        chk({nm, "_last"},  dout_last, 0);
        chk({nm, "_valid"}, dout_valid, 0);
        chk({nm, "_ovf"},   overflow, 0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst_n     = 1'b0;
        sin_valid = 1'b0;
        sin       = 1'b0;
        #1;
        check_reset_outputs(nm);
        idle(2);
        rst_n = 1'b1;
        popped.delete();
        valid_cycles = 0;
    endtask

    task automatic check_pops(input string nm);
        chk({nm, "_npops"}, popped.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            chk($sformatf("%s_pop%0d", nm, i), (i < popped.size()) ? popped[i] : 13'h1fff, want[i]);
    endtask

    initial begin
        rst_n        = 1'b0;
        sin          = 1'b0;
        sin_valid    = 1'b0;
        dout_ready   = 1'b0;
        exp_ovf      = 1'b0;
        valid_cycles = 0;
        #1;
        check_reset_outputs("rst0");
        idle(2);
        rst_n = 1'b1;

        // Single full word
        dout_ready = 1'b1;
        popped.delete();
        valid_cycles = 0;
        send_bits(64'hA6, 8);
        end_burst();
        idle(4);
        want = '{{8'hA6, 4'd8, 1'b1}};
        check_pops("single");
        chk("single_valid_cycles", valid_cycles, 1);

        // Full word plus partial
        popped.delete();
        send_bits(64'b11111111101, 11);
        end_burst();
        idle(4);
        want = '{{8'hFF, 4'd8, 1'b0}, {8'hA0, 4'd3, 1'b1}};
        check_pops("partial");

        // Contiguous 16-bit burst
        popped.delete();
        send_bits(64'h1234, 16);
        end_burst();
        idle(4);
        want = '{{8'h12, 4'd8, 1'b0}, {8'h34, 4'd8, 1'b1}};
        check_pops("contig");

        // Overflow
        dout_ready = 1'b0;
        popped.delete();
        for (int k = 1; k <= 5; k++) begin
            send_bits(64'(k), 8);
            end_burst();
        end
        idle(1);
        chk("ovf_set", overflow, 1);
        dout_ready = 1'b1;
        idle(7);
        want = '{{8'h01, 4'd8, 1'b1}, {8'h02, 4'd8, 1'b1},
                 {8'h03, 4'd8, 1'b1}, {8'h04, 4'd8, 1'b1}};
        check_pops("ovf");
        chk("ovf_sticky", overflow, 1);
        do_reset("rst_ovf");

        // Push and pop on a full FIFO
        dout_ready = 1'b0;
        send_bits(64'h11, 8); end_burst();
        send_bits(64'h22, 8); end_burst();
        send_bits(64'h33, 8); end_burst();
        send_bits(64'h44, 8); end_burst();
        idle(1);
        send_bits(64'h99, 8);
        @(negedge clk);
        sin_valid  = 1'b0;
        sin        = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        idle(1);
        chk("pp_ovf", overflow, 0);
        chk("pp_valid", dout_valid, 1);
        chk("pp_head", dout, 8'h22);
        dout_ready = 1'b1;
        idle(7);
        want = '{{8'h11, 4'd8, 1'b1}, {8'h22, 4'd8, 1'b1}, {8'h33, 4'd8, 1'b1},
                 {8'h44, 4'd8, 1'b1}, {8'h99, 4'd8, 1'b1}};
        check_pops("pp");
        chk("pp_ovf_end", overflow, 0);

        // Reset mid-burst
        send_bits(64'b10110, 5);
        do_reset("rst_mid");
        send_bits(64'h3C, 8);
        end_burst();
        idle(5);
        want = '{{8'h3C, 4'd8, 1'b1}};
        check_pops("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/final_out_deser.md
# final_out_deser

Serial-to-parallel collector directly downstream of the `Final` core. It consumes the core's 1-bit `OUT` / `OUT_VALID` stream and packs each burst MSB-first into WIDTH-bit words. Words are buffered in a DEPTH-entry FIFO and presented on a valid/ready port. Each word carries a bit count and an end-of-burst flag.

## Interface
- `WIDTH`, default 8: word width in bits; must be ≥ 2.
- `DEPTH`, default 4: FIFO entries; must be a power of 2 and ≥ 2.
- `CLK`  in  1: single clock; all state is updated on the rising edge.
- `RST`  in  1: asynchronous, active-low reset.
- `SIN`  in  1: serial data bit, connected to `Final.OUT`.
- `SIN_VALID`  in  1: `SIN` is valid this cycle, connected to `Final.OUT_VALID`.
- `DOUT`  out  WIDTH: head-of-FIFO word, left-aligned.
- `DOUT_NBITS`  out  $clog2(WIDTH+1): number of meaningful bits in `DOUT`, range 1..WIDTH.
- `DOUT_LAST`  out  1: `DOUT` is the final word of its burst.
- `DOUT_VALID`  out  1: FIFO is non-empty.
- `DOUT_READY`  in  1: consumer accepts the head word.
- `OVERFLOW`  out  1: sticky flag; set when a word is dropped.

## Operation
- **Packer state:** shift register `sh[WIDTH-1:0]` and counter `cnt`, range 0..WIDTH. `cnt==WIDTH` means a complete word is pending.
- **`SIN_VALID=1` and `cnt<WIDTH`:**
  - `sh <= {sh[WIDTH-2:0], SIN}`
  - `cnt <= cnt+1`
- **`SIN_VALID=1` and `cnt==WIDTH`:**
  - Push `{sh, NBITS=WIDTH, LAST=0}`.
  - `sh <= {0…, SIN}`
  - `cnt <= 1`
  - No bit is lost across word boundaries.
- **`SIN_VALID=0` and `cnt>0`:**
  - Push `{sh << (WIDTH-cnt), NBITS=cnt, LAST=1}`, zero-padded in the LSBs.
  - `cnt <= 0`
  - This covers the pending full word (`cnt==WIDTH`, shift of 0) and partial words alike.
- **`SIN_VALID=0` and `cnt==0`:** no action. `SIN` is ignored whenever `SIN_VALID=0`.
- **Single-cycle gap:** a one-cycle drop of `SIN_VALID` ends the burst. The next high cycle starts a new burst at `cnt=0`.
- **FIFO:**
  - Circular buffer with a write pointer, a read pointer and an occupancy count of 0..DEPTH.
  - `DOUT*` are driven from the head entry.
  - `DOUT_VALID = (count != 0)`.
  - Pop when `DOUT_VALID && DOUT_READY`.
- **Push while full:**
  - With a pop in the same cycle: both the push and the pop are performed and count is unchanged.
  - Without a pop: the word is dropped, `OVERFLOW <= 1`, and packer state advances normally.
- **Reset clearing:** `OVERFLOW` is cleared only by `RST`.
- **Don't-care outputs:** `DOUT`, `DOUT_NBITS` and `DOUT_LAST` are don't-care while `DOUT_VALID=0`.

## Timing
- **Reset (`RST=0`), asynchronous, regardless of state:**
  - All outputs 0: `DOUT=0`, `DOUT_NBITS=0`, `DOUT_LAST=0`, `DOUT_VALID=0`, `OVERFLOW=0`.
  - `sh=0`, `cnt=0`, FIFO empty with both pointers at 0.
  - A burst in progress is discarded. Words already in the FIFO are discarded.
- **Mid-word boundary:** when word k+1 continues without a gap, word k is pushed at the edge that samples bit 1 of word k+1.
- **End of burst:** the final word of a burst is pushed at the edge that samples the first `SIN_VALID=0`.
- **Latency to output:** `DOUT_VALID` rises after the push edge, i.e. 1 cycle after the last bit of the word when no pops are pending.
- **Handshake rules:**
  - A word is held stable on `DOUT*` until popped.
  - `DOUT_VALID` never drops without a pop.
  - Back-to-back pops are allowed every cycle.
  - Sustained throughput is 1 bit per cycle in and 1 word per cycle out, with no stalls when `DOUT_READY=1`.
- **Simultaneous push and pop on an empty FIFO:** no bypass. The word appears the next cycle.
- **No combinational paths** from `SIN` or `SIN_VALID` to any output. `DOUT_VALID` depends only on registered state.

## Test plan
All scenarios use WIDTH=8, DEPTH=4. Edge numbers count from the first sampled bit = edge 1.
- **Single full word:** reset, then `DOUT_READY=1`; drive 8 bits 1,0,1,0,0,1,1,0 on edges 1–8, idle at edge 9. Required: `DOUT=0xA6`, `NBITS=8`, `LAST=1`, `DOUT_VALID` high for exactly one cycle after edge 9.
- **Full word plus partial:** burst of 11 bits, 0xFF followed by 1,0,1. Required: word 1 is `0xFF` with `NBITS=8`, `LAST=0`; word 2 is `0xA0` with `NBITS=3`, `LAST=1`.
- **Contiguous 16-bit burst:** 0x12 then 0x34. Required: `0x12` with `LAST=0`, then `0x34` with `LAST=1`; no bit slip.
- **Overflow:** `DOUT_READY=0`; send five separate 8-bit bursts 0x01..0x05. Required: `OVERFLOW=1` after the fifth push edge. Then set `DOUT_READY=1`: pops are 0x01..0x04 in order, 0x05 is absent, and `OVERFLOW` remains 1.
- **Push and pop on a full FIFO:** fill the FIFO to 4 entries; pulse `DOUT_READY` in the same cycle as a push of 0x99. Required: count stays 4, `OVERFLOW=0`, and 0x99 is popped fifth.
- **Reset mid-burst:** assert `RST` low after 5 bits, release it, then send 0x3C as an 8-bit burst. Required: all outputs are 0 during reset, and the only word afterwards is `0x3C` with `NBITS=8`, `LAST=1`.
